fft_output_serializer: RTL and testbench
========================================

// Module: fft_output_serializer
// PURPOSE
//  Receive end of the 4-lane FFT datapath: accepts 4 parallel samples per beat from the last
//  commutator/butterfly stage, buffers one frame in a ping-pong store, emits one sample per
//  beat in natural order (base-4 digit reversal undone). valid/ready on both sides, so the
//  FFT pipeline stalls instead of losing data when the downstream consumer is slow.
// PARAMETERS
//  NB     16  bits per sample (one lane)
//  LOG4N  2   log4 of frame length; N = 4**LOG4N samples, W = N/4 input words per frame
//  BITREV 1   1: output reorder by base-4 digit reversal; 0: output in arrival order
// PORTS
//  clk        in   1     clock, rising edge
//  reset_n    in   1     asynchronous, active-low reset
//  start      in   1     synchronous flush / frame restart pulse
//  in_valid   in   1     in_data holds a word
//  in_data    in   4*NB  lane l = in_data[NB*(l+1)-1:NB*l], l=0..3
//  in_ready   out  1     word accepted on edge where in_valid & in_ready
//  out_valid  out  1     out_data holds a sample
//  out_data   out  NB    output sample
//  out_ready  in   1     sample consumed on edge where out_valid & out_ready
//  out_last   out  1     high with the final sample (k = N-1) of a frame
//  done       out  1     1-cycle pulse, cycle after the last sample of a frame is consumed
// BEHAVIOUR
//  - Reset (async): both banks empty, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0; in_ready=1,
//    out_valid=0, out_last=0, done=0, out_data=0. Memory contents not reset.
//  - Store: 2 banks x 4 lane arrays x W entries. Word w of a frame holds samples s=4w+l.
//  - Write: on accepted beat, lanes written at entry wr_cnt of bank wr_bank; wr_cnt++.
//    On accepting word W-1: full[wr_bank]<=1, wr_cnt<=0, wr_bank toggles.
//  - in_ready = ~full[wr_bank] & ~start (combinational from registers and start).
//  - Read: out_valid = full[rd_bank]. Output index k=rd_cnt; s = BITREV ? rev4(k) : k,
//    rev4 = reverse of the LOG4N base-4 digits of k; out_data = bank[rd_bank].lane[s%4][s/4]
//    while out_valid, else 0. out_last = out_valid & (rd_cnt==N-1).
//  - On consumed sample rd_cnt++; on consuming k=N-1: full[rd_bank]<=0, rd_cnt<=0,
//    rd_bank toggles, done<=1 next cycle (registered pulse, 1 cycle).
//  - Latency: out_valid rises the cycle after the edge accepting word W-1 (read bank empty).
//    Sustained throughput 1 frame per N cycles out; input side may burst 2 frames ahead.
//  - Both banks full: in_ready=0 until the read bank drains; no overwrite, no drop.
//  - Write and read in the same cycle always target different banks; full flags for two banks
//    update independently in that cycle (fill one, free other).
//  - out_data/out_last stable while out_valid & ~out_ready.
//  - start (priority over everything but reset): next edge clears both full flags, counters,
//    bank pointers; partial and buffered frames discarded; in_valid beat that cycle dropped;
//    done not pulsed. out_valid=0 from the cycle after start.
//  - Reset mid-frame: outputs go to reset values immediately (asynchronous).
//  - No overflow/underflow states exist; out_ready while out_valid=0 ignored.
// TESTING (NB=16, LOG4N=2 => N=16, W=4 unless stated)
//  1. Reset: assert reset_n=0 during traffic -> same cycle out_valid=0, out_last=0, done=0,
//     out_data=0, in_ready=1; after release first frame behaves as from power-up.
//  2. BITREV=0, out_ready=1: words w=0..3 with lane l = 4w+l -> out 0,1,...,15, out_last at 15,
//     out_valid rises 1 cycle after word 3 accepted, done pulses cycle after sample 15.
//  3. BITREV=1, same stimulus -> out 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; LOG4N=3 run:
//     k=1 -> s=16, k=16 -> s=1.
//  4. Backpressure: out_ready=0, stream 3 frames -> in_ready drops after 8th word accepted;
//     release out_ready -> frames 1,2,3 output in order, no drop/duplicate, 3 done pulses.
//  5. Random out_ready/in_valid toggling over 50 frames vs scoreboard model -> exact match,
//     out_data stable whenever out_valid & ~out_ready.
//  6. start after 2 words of frame A (plus one full frame buffered) -> buffered frame and A
//     discarded, no done; next full frame B output correctly as first frame.

Source files
------------

// File: rtl/fft_output_serializer_if.sv
// Stream bundle for the FFT output serializer: 4-lane input words in, one sample per beat out.
// A word or a sample moves only on a rising edge where valid and ready are both high. A producer
// holding valid keeps its data stable until that edge, and ready never waits on valid.
interface fft_output_serializer_if #(
  parameter int NB = 16
);
  logic            in_valid;
  logic [4*NB-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic [NB-1:0]   out_data;
  logic            out_ready;
  logic            out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fft_output_serializer.sv
// Ping-pong frame buffer behind the 4-lane FFT: takes 4 samples per beat and emits one
// sample per beat in natural order, undoing the base-4 digit reversal when BITREV=1.
module fft_output_serializer #(
  parameter int NB     = 16,
  parameter int LOG4N  = 2,
  parameter int BITREV = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  fft_output_serializer_if.slave  bus,
  output logic                    done
);
  localparam int N  = 4 ** LOG4N;
  localparam int W  = N / 4;
  localparam int KW = 2 * LOG4N;
  localparam int WW = (LOG4N > 1) ? 2 * LOG4N - 2 : 1;

  logic [NB-1:0] mem [2][4][W];

  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [WW-1:0] wr_cnt;
  logic [KW-1:0] rd_cnt;

  logic          in_fire;
  logic          out_fire;
  logic [KW-1:0] s_idx;
  logic [WW-1:0] s_word;

  function automatic logic [KW-1:0] rev4(input logic [KW-1:0] k);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < LOG4N; i++) begin
      r[2*i +: 2] = k[2*(LOG4N-1-i) +: 2];
    end
    return r;
  endfunction

  // The write bank is never full when a word is accepted, and the read bank is always
  // full when a sample is consumed, so both can act in one cycle without colliding.
  assign bus.in_ready  = ~full[wr_bank] & ~start;
  assign bus.out_valid = full[rd_bank];
  assign bus.out_last  = bus.out_valid & (rd_cnt == KW'(N - 1));
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready & ~start;

  assign s_idx        = (BITREV != 0) ? rev4(rd_cnt) : rd_cnt;
  assign s_word       = WW'(s_idx >> 2);
  assign bus.out_data = bus.out_valid ? mem[rd_bank][s_idx[1:0]][s_word] : '0;

  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int l = 0; l < 4; l++) begin
        mem[wr_bank][l][wr_cnt] <= bus.in_data[NB*l +: NB];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      done    <= 1'b0;
    end else if (start) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_fire) begin
        if (wr_cnt == WW'(W - 1)) begin
          full[wr_bank] <= 1'b1;
          wr_cnt        <= '0;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + WW'(1);
        end
      end
      if (out_fire) begin
        if (rd_cnt == KW'(N - 1)) begin
          full[rd_bank] <= 1'b0;
          rd_cnt        <= '0;
          rd_bank       <= ~rd_bank;
          done          <= 1'b1;
        end else begin
          rd_cnt <= rd_cnt + KW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_output_serializer.sv
// Bench for fft_output_serializer: three instances (digit-reversed N=16, arrival-order N=16,
// digit-reversed N=64) compared each cycle against a frame-level reference model.
module tb_fft_output_serializer;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic done_a, done_b, done_c;

  int total = 0;
  int bad = 0;
  int mode = 0;

  logic [NB:0]   exp_q [3][$];
  logic [NB-1:0] cur   [3][$];
  bit            done_exp [3];

  fft_output_serializer_if #(.NB(NB)) bus_a ();
  fft_output_serializer_if #(.NB(NB)) bus_b ();
  fft_output_serializer_if #(.NB(NB)) bus_c ();

  fft_output_serializer #(.NB(NB), .LOG4N(2), .BITREV(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus_a), .done(done_a)
  );
  fft_output_serializer #(.NB(NB), .LOG4N(2), .BITREV(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus_b), .done(done_b)
  );
  fft_output_serializer #(.NB(NB), .LOG4N(3), .BITREV(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus_c), .done(done_c)
  );

  // dut_b sees exactly the traffic of dut_a; handshakes do not depend on BITREV.
  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.out_ready = bus_a.out_ready;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev_digits(input int k, input int log4n);
    int r = 0;
    int x = k;
    for (int d = 0; d < log4n; d++) begin
      r = r * 4 + x % 4;
      x = x / 4;
    end
    return r;
  endfunction

  // Compare one instance against the model, then apply this cycle's handshakes to the model.
  task automatic check_port(input int id, input int log4n, input bit bitrev,
                            input logic iv, input logic ir, input logic [4*NB-1:0] idata,
                            input logic ov, input logic ordy, input logic [NB-1:0] od,
                            input logic ol, input logic dn, input logic st);
    int n = 4 ** log4n;
    int pend;
    logic [NB:0] head;
    pend = (exp_q[id].size() + n - 1) / n;
    head = (pend > 0) ? exp_q[id][0] : '0;
    chk($sformatf("in_ready[%0d]", id), ir, (!st && pend < 2));
    chk($sformatf("out_valid[%0d]", id), ov, (pend > 0));
    chk($sformatf("out_data[%0d]", id), od, head[NB-1:0]);
    chk($sformatf("out_last[%0d]", id), ol, head[NB]);
    chk($sformatf("done[%0d]", id), dn, done_exp[id]);
    done_exp[id] = 1'b0;
    if (st) begin
      exp_q[id].delete();
      cur[id].delete();
    end else begin
      if (ov && ordy && pend > 0) begin
        void'(exp_q[id].pop_front());
        if (head[NB]) done_exp[id] = 1'b1;
      end
      if (iv && ir) begin
        for (int l = 0; l < 4; l++) cur[id].push_back(idata[NB*l +: NB]);
        if (cur[id].size() == n) begin
          for (int k = 0; k < n; k++) begin
            int s;
            s = bitrev ? rev_digits(k, log4n) : k;
            exp_q[id].push_back({(k == n - 1), cur[id][s]});
          end
          cur[id].delete();
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int i = 0; i < 3; i++) begin
          exp_q[i].delete();
          cur[i].delete();
          done_exp[i] = 1'b0;
        end
      end else begin
        check_port(0, 2, 1'b1, bus_a.in_valid, bus_a.in_ready, bus_a.in_data, bus_a.out_valid,
                   bus_a.out_ready, bus_a.out_data, bus_a.out_last, done_a, start);
        check_port(1, 2, 1'b0, bus_b.in_valid, bus_b.in_ready, bus_b.in_data, bus_b.out_valid,
                   bus_b.out_ready, bus_b.out_data, bus_b.out_last, done_b, start);
        check_port(2, 3, 1'b1, bus_c.in_valid, bus_c.in_ready, bus_c.in_data, bus_c.out_valid,
                   bus_c.out_ready, bus_c.out_data, bus_c.out_last, done_c, start);
      end
    end
  end

  // out_ready: 0 = held low, 1 = held high, 2 = random each cycle.
  initial begin
    bus_a.out_ready = 1'b0;
    bus_c.out_ready = 1'b0;
    forever begin
      logic r;
      @(posedge clk);
      #1;
      r = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
      bus_a.out_ready = r;
      bus_c.out_ready = r;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int port, input logic [4*NB-1:0] d);
    bit ok = 1'b0;
    int budget = 0;
    if (port == 0) begin bus_a.in_valid = 1'b1; bus_a.in_data = d; end
    else begin bus_c.in_valid = 1'b1; bus_c.in_data = d; end
    do begin
      @(negedge clk);
      ok = (port == 0) ? bus_a.in_ready : bus_c.in_ready;
      tick();
      budget++;
    end while (!ok && budget < 3000);
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    if (port == 0) bus_a.in_valid = 1'b0;
    else bus_c.in_valid = 1'b0;
  endtask

  // seq=1 fills lane l of word w with 4w+l; otherwise random samples.
  task automatic send_words(input int port, input int words, input bit seq, input int gap);
    for (int w = 0; w < words; w++) begin
      logic [4*NB-1:0] d;
      for (int l = 0; l < 4; l++) d[NB*l +: NB] = seq ? NB'(4 * w + l) : NB'($urandom);
      send_word(port, d);
      repeat ($urandom_range(0, gap)) tick();
    end
  endtask

  task automatic wait_drain();
    int b = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0 ||
            done_exp[0] || done_exp[1] || done_exp[2]) && b < 5000) begin
      tick();
      b++;
    end
    if (b >= 5000) chk("drain_timeout", 64'd0, 64'd1);
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus_a.in_ready, 64'd1);
    chk({tag, "_out_valid"}, bus_a.out_valid, 64'd0);
    chk({tag, "_out_last"}, bus_a.out_last, 64'd0);
    chk({tag, "_out_data"}, bus_a.out_data, 64'd0);
    chk({tag, "_done"}, done_a, 64'd0);
    chk({tag, "_c_out_valid"}, bus_c.out_valid, 64'd0);
  endtask

  initial begin
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = '0;
    bus_c.in_valid = 1'b0;
    bus_c.in_data  = '0;
    #2;
    check_reset_outputs("por");
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Ordered frame, consumer always ready: natural and digit-reversed outputs, latency, done.
    mode = 1;
    send_words(0, 4, 1'b1, 0);
    wait_drain();

    // Backpressure: three frames against a stalled consumer, then release.
    mode = 0;
    fork
      send_words(0, 12, 1'b0, 0);
      begin
        repeat (30) tick();
        mode = 1;
      end
    join
    wait_drain();

    // start with one frame buffered and two words of a second frame in flight.
    mode = 0;
    send_words(0, 4, 1'b0, 0);
    send_words(0, 2, 1'b0, 0);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = {$urandom, $urandom};
    start = 1'b1;
    tick();
    start = 1'b0;
    bus_a.in_valid = 1'b0;
    mode = 1;
    send_words(0, 4, 1'b1, 0);
    wait_drain();

    // Asynchronous reset in the middle of traffic.
    mode = 0;
    send_words(0, 6, 1'b0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    reset_n = 1'b1;
    tick();
    mode = 1;
    send_words(0, 4, 1'b1, 0);
    wait_drain();

    // Random traffic on both sides.
    mode = 2;
    for (int f = 0; f < 50; f++) send_words(0, 4, 1'b0, 2);
    wait_drain();

    // N=64 instance: ordered frame then random frame.
    mode = 2;
    send_words(1, 16, 1'b1, 1);
    send_words(1, 16, 1'b0, 1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
